// File: rtl/legv8_pkg.sv
// Shared LEGv8 core definitions: writeback FSM states and register-file constants.
package legv8_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wb_state_t;

  localparam int XZR_IDX   = 31;
  localparam int REG_IDX_W = 5;

endpackage

// File: rtl/writeback_stage.sv
// LEGv8 writeback stage: captures retiring instructions, waits for load data,
// and emits a one-cycle register-file write pulse plus a forwarding view.
module writeback_stage
  import legv8_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int ZERO_REG = XZR_IDX,
  parameter int CNT_W    = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic                 in_regwrite,
  input  logic                 in_memtoreg,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic [REG_IDX_W-1:0] wreg,
  output logic [XLEN-1:0]      wdata,
  output logic                 REGWRITE,
  output logic                 fwd_valid,
  output logic [REG_IDX_W-1:0] fwd_reg,
  output logic [XLEN-1:0]      fwd_data,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [REG_IDX_W-1:0] ZR = REG_IDX_W'(ZERO_REG);

  wb_state_t            state;
  logic [REG_IDX_W-1:0] rd_p0;
  logic                 regwrite_p0;
  logic                 xfer;

  assign in_ready = (state != WAIT_MEM);
  assign xfer     = in_valid && in_ready;

  // Forwarding mirrors the commit registers; only valid while a real write pulses.
  assign fwd_valid = REGWRITE;
  assign fwd_reg   = wreg;
  assign fwd_data  = wdata;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      rd_p0       <= '0;
      regwrite_p0 <= 1'b0;
      wreg        <= '0;
      wdata       <= '0;
      REGWRITE    <= 1'b0;
      retired     <= '0;
    end else begin
      REGWRITE <= 1'b0;
      if (state == COMMIT)
        retired <= retired + CNT_W'(1);
      case (state)
        IDLE, COMMIT: begin
          if (xfer) begin
            if (in_memtoreg) begin
              rd_p0       <= in_rd;
              regwrite_p0 <= in_regwrite;
              state       <= WAIT_MEM;
            end else begin
              wreg     <= in_rd;
              wdata    <= in_alu_result;
              REGWRITE <= in_regwrite && (in_rd != ZR);
              state    <= COMMIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT_MEM: begin
          // Pending rd stays private until the load data arrives, so wreg/wdata hold.
          if (mem_rvalid) begin
            wreg     <= rd_p0;
            wdata    <= mem_rdata;
            REGWRITE <= regwrite_p0 && (rd_p0 != ZR);
            state    <= COMMIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU, load, XZR/store, reset and counter wrap.
module tb_writeback_stage;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [63:0] in_alu_result = '0;
  logic        in_regwrite = 1'b0;
  logic        in_memtoreg = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;

  logic        in_ready, REGWRITE, fwd_valid;
  logic [4:0]  wreg, fwd_reg;
  logic [63:0] wdata, fwd_data;
  logic [31:0] retired;

  logic        in_ready4, regwrite4, fwd_valid4;
  logic [4:0]  wreg4, fwd_reg4;
  logic [63:0] wdata4, fwd_data4;
  logic [3:0]  retired4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  writeback_stage dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_alu_result(in_alu_result), .in_regwrite(in_regwrite),
    .in_memtoreg(in_memtoreg), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wreg(wreg), .wdata(wdata), .REGWRITE(REGWRITE), .fwd_valid(fwd_valid),
    .fwd_reg(fwd_reg), .fwd_data(fwd_data), .retired(retired)
  );

  writeback_stage #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready4),
    .in_rd(in_rd), .in_alu_result(in_alu_result), .in_regwrite(in_regwrite),
    .in_memtoreg(in_memtoreg), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wreg(wreg4), .wdata(wdata4), .REGWRITE(regwrite4), .fwd_valid(fwd_valid4),
    .fwd_reg(fwd_reg4), .fwd_data(fwd_data4), .retired(retired4)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_rd = '0; in_alu_result = '0;
    in_regwrite = 1'b0; in_memtoreg = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 RST_N = 1'b0;
    #3 RST_N = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RST_N = 1'b1;
    tick();
    // Put something non-zero on the outputs first.
    in_valid = 1'b1; in_rd = 5'd12; in_alu_result = 64'hDEAD; in_regwrite = 1'b1;
    tick();
    in_valid = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if ({REGWRITE, fwd_valid, wreg, fwd_reg} !== 12'd0) begin
      $display("FAIL reset_ctrl: got RW=%b FV=%b wreg=%0d freg=%0d, want all 0", REGWRITE, fwd_valid, wreg, fwd_reg); n_fail++;
    end
    n_checks++;
    if (wdata !== 64'd0 || fwd_data !== 64'd0) begin
      $display("FAIL reset_data: got wdata=%h fwd_data=%h, want 0", wdata, fwd_data); n_fail++;
    end
    n_checks++;
    if (retired !== 32'd0 || in_ready !== 1'b1) begin
      $display("FAIL reset_cnt_ready: got retired=%0d in_ready=%b, want 0/1", retired, in_ready); n_fail++;
    end
    #2 RST_N = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; in_rd = 5'd5; in_alu_result = 64'hAAAA; in_regwrite = 1'b1;
    tick();
    n_checks++;
    if (REGWRITE !== 1'b1 || wreg !== 5'd5 || wdata !== 64'hAAAA) begin
      $display("FAIL b2b_first: got RW=%b wreg=%0d wdata=%h, want 1/5/aaaa", REGWRITE, wreg, wdata); n_fail++;
    end
    n_checks++;
    if (in_ready !== 1'b1 || fwd_valid !== 1'b1 || fwd_reg !== 5'd5 || fwd_data !== 64'hAAAA) begin
      $display("FAIL b2b_fwd: got rdy=%b FV=%b freg=%0d fdata=%h, want 1/1/5/aaaa", in_ready, fwd_valid, fwd_reg, fwd_data); n_fail++;
    end
    in_rd = 5'd6; in_alu_result = 64'hBBBB;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (REGWRITE !== 1'b1 || wreg !== 5'd6 || wdata !== 64'hBBBB) begin
      $display("FAIL b2b_second: got RW=%b wreg=%0d wdata=%h, want 1/6/bbbb", REGWRITE, wreg, wdata); n_fail++;
    end
    tick();
    n_checks++;
    if (REGWRITE !== 1'b0 || retired !== 32'd2 || wdata !== 64'hBBBB) begin
      $display("FAIL b2b_done: got RW=%b retired=%0d wdata=%h, want 0/2/bbbb", REGWRITE, retired, wdata); n_fail++;
    end
  endtask

  task automatic test_load_wait();
    do_reset();
    in_valid = 1'b1; in_rd = 5'd7; in_alu_result = 64'h100; in_regwrite = 1'b1; in_memtoreg = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || fwd_valid !== 1'b0 || REGWRITE !== 1'b0 || wreg !== 5'd0) begin
        $display("FAIL load_wait%0d: got rdy=%b FV=%b RW=%b wreg=%0d, want 0/0/0/0", i, in_ready, fwd_valid, REGWRITE, wreg); n_fail++;
      end
      if (i == 2) begin mem_rvalid = 1'b1; mem_rdata = 64'h1234; end
      tick();
    end
    mem_rvalid = 1'b0; mem_rdata = 64'hFFFF;
    n_checks++;
    if (REGWRITE !== 1'b1 || wreg !== 5'd7 || wdata !== 64'h1234 || fwd_valid !== 1'b1 || fwd_data !== 64'h1234) begin
      $display("FAIL load_commit: got RW=%b wreg=%0d wdata=%h FV=%b, want 1/7/1234/1", REGWRITE, wreg, wdata, fwd_valid); n_fail++;
    end
    tick();
    n_checks++;
    if (REGWRITE !== 1'b0 || wdata !== 64'h1234 || retired !== 32'd1 || in_ready !== 1'b1) begin
      $display("FAIL load_after: got RW=%b wdata=%h retired=%0d rdy=%b, want 0/1234/1/1", REGWRITE, wdata, retired, in_ready); n_fail++;
    end
  endtask

  task automatic test_min_load_latency();
    do_reset();
    in_valid = 1'b1; in_rd = 5'd3; in_regwrite = 1'b1; in_memtoreg = 1'b1;
    tick();
    idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 64'h77;
    tick();
    mem_rvalid = 1'b0;
    n_checks++;
    if (REGWRITE !== 1'b1 || wreg !== 5'd3 || wdata !== 64'h77) begin
      $display("FAIL load_min: got RW=%b wreg=%0d wdata=%h, want 1/3/77", REGWRITE, wreg, wdata); n_fail++;
    end
    // A stray response outside WAIT_MEM must not produce a write.
    mem_rvalid = 1'b1; mem_rdata = 64'h99;
    tick();
    tick();
    mem_rvalid = 1'b0;
    n_checks++;
    if (REGWRITE !== 1'b0 || wdata !== 64'h77 || retired !== 32'd1) begin
      $display("FAIL stray_rvalid: got RW=%b wdata=%h retired=%0d, want 0/77/1", REGWRITE, wdata, retired); n_fail++;
    end
  endtask

  task automatic test_xzr_store();
    do_reset();
    in_valid = 1'b1; in_rd = 5'd31; in_alu_result = 64'h55; in_regwrite = 1'b1;
    tick();
    n_checks++;
    if (REGWRITE !== 1'b0 || fwd_valid !== 1'b0) begin
      $display("FAIL xzr_write: got RW=%b FV=%b, want 0/0", REGWRITE, fwd_valid); n_fail++;
    end
    in_rd = 5'd3; in_alu_result = 64'h66; in_regwrite = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (REGWRITE !== 1'b0 || fwd_valid !== 1'b0) begin
      $display("FAIL store_write: got RW=%b FV=%b, want 0/0", REGWRITE, fwd_valid); n_fail++;
    end
    tick();
    n_checks++;
    if (retired !== 32'd2) begin
      $display("FAIL xzr_store_count: got retired=%0d, want 2", retired); n_fail++;
    end
  endtask

  task automatic test_reset_wait_mem();
    do_reset();
    in_valid = 1'b1; in_rd = 5'd9; in_regwrite = 1'b1; in_memtoreg = 1'b1;
    tick();
    idle_inputs();
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL rst_wait_ready: got in_ready=%b, want 1", in_ready); n_fail++;
    end
    #2 RST_N = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'hABCD;
    tick();
    mem_rvalid = 1'b0;
    n_checks++;
    if (REGWRITE !== 1'b0 || wreg !== 5'd0 || wdata !== 64'd0 || in_ready !== 1'b1) begin
      $display("FAIL rst_wait_drop: got RW=%b wreg=%0d wdata=%h rdy=%b, want 0/0/0/1", REGWRITE, wreg, wdata, in_ready); n_fail++;
    end
    tick();
    n_checks++;
    if (retired !== 32'd0 || REGWRITE !== 1'b0) begin
      $display("FAIL rst_wait_count: got retired=%0d RW=%b, want 0/0", retired, REGWRITE); n_fail++;
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    in_valid = 1'b1; in_rd = 5'd1; in_regwrite = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_alu_result = 64'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (retired4 !== 4'd1) begin
      $display("FAIL cnt_wrap: got retired4=%0d, want 1", retired4); n_fail++;
    end
    n_checks++;
    if (retired !== 32'd17 || wdata !== 64'd16) begin
      $display("FAIL cnt_wide: got retired=%0d wdata=%0d, want 17/16", retired, wdata); n_fail++;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_load_wait();
    test_min_load_latency();
    test_xzr_store();
    test_reset_wait_mem();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
